// File: rtl/pipeline_cpu_fetch.sv
// pipeline_cpu_fetch: IF stage owning the PC, imem ready handshake and IF/ID register.
// Define FETCH_PERF_CNT_EN to add perf_fetched/perf_bubbles counters.
module pipeline_cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] id_instruction,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`else
  output logic [31:0] id_instruction
`endif
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state, nextState;
  logic [31:0] pc, holdBuf, loadData, target;
  logic load, bubble, capture;
  always_ff @(posedge clk)
    if (rst) state <= FETCH;
    else state <= nextState;
  always_comb
    nextState = redirect ? FETCH :
                (state == HOLD) ? (stall ? HOLD : FETCH) :
                (imem_ready && stall) ? HOLD : FETCH;
  always_comb begin
    imem_addr = pc;
    imem_req = (state == FETCH) && !rst;
    target = redirect_target & ~32'd3;
    load = !redirect && !stall && (state == HOLD || imem_ready);
    bubble = redirect || (state == FETCH && !imem_ready && !stall);
    capture = !redirect && stall && state == FETCH && imem_ready;
    loadData = (state == HOLD) ? holdBuf : imem_rdata;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_PC;
      holdBuf <= '0;
      id_valid <= 1'b0;
      id_pc <= '0;
      id_pc_plus4 <= '0;
      id_instruction <= NOP_INSTR;
    end else begin
      if (redirect) pc <= target;
      else if (load) pc <= pc + 32'd4;
      if (capture) holdBuf <= imem_rdata;
      if (load) {id_valid, id_pc, id_pc_plus4, id_instruction} <= {1'b1, pc, pc + 32'd4, loadData};
      else if (bubble) begin
        id_valid <= 1'b0;
        id_instruction <= NOP_INSTR;
      end
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (load) perf_fetched <= perf_fetched + 32'd1;
      if (bubble) perf_bubbles <= perf_bubbles + 32'd1;
    end
`endif
endmodule
